// File: rtl/mem_slot_arb_if.sv
// Slot arbiter bus: slot strobe and level requests toward the arbiter,
// one-hot grants, refresh flag, completion pulses and busy back from it.
interface mem_slot_arb_if;
  logic       c3;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_ref;
  logic [3:0] ack;
  logic       busy;

  modport master (
    output c3,
    output req,
    input  gnt,
    input  gnt_ref,
    input  ack,
    input  busy
  );

  modport slave (
    input  c3,
    input  req,
    output gnt,
    output gnt_ref,
    output ack,
    output busy
  );
endinterface

// File: rtl/mem_slot_arb.sv
// Memory slot arbiter: one owner per c3-delimited slot, chosen as
// refresh > capped video > round-robin cpu/dma/tilemap > idle.
module mem_slot_arb #(
  parameter int VID_MAX = 3,
  parameter int REF_INT = 64
) (
  input logic           clk,
  input logic           rst,
  mem_slot_arb_if.slave bus
);

  localparam logic [2:0] VID_CAP    = 3'(VID_MAX);
  localparam logic [7:0] REF_RELOAD = 8'(REF_INT - 1);
  localparam logic [1:0] RR_NONE    = 2'd0;
  localparam logic [1:0] RR_CPU     = 2'd1;
  localparam logic [1:0] RR_DMA     = 2'd2;
  localparam logic [1:0] RR_TM      = 2'd3;

  logic [3:0] gnt_q,      gnt_d;
  logic       gnt_ref_q,  gnt_ref_d;
  logic [3:0] ack_q,      ack_d;
  logic       busy_q,     busy_d;
  logic [2:0] vid_run_q,  vid_run_d;
  logic [7:0] ref_cnt_q,  ref_cnt_d;
  logic       ref_pend_q, ref_pend_d;
  logic [1:0] rr_q,       rr_d;

  logic       ref_expire_s;
  logic       vid_capped_s;
  logic [1:0] rr_win_s;

  // cand[0]=cpu, cand[1]=dma, cand[2]=tilemap; search starts after 'last'.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] cand);
    logic [1:0] win;
    win = RR_NONE;
    case (last)
      RR_CPU: begin
        if (cand[1])      win = RR_DMA;
        else if (cand[2]) win = RR_TM;
        else if (cand[0]) win = RR_CPU;
        else              win = RR_NONE;
      end
      RR_DMA: begin
        if (cand[2])      win = RR_TM;
        else if (cand[0]) win = RR_CPU;
        else if (cand[1]) win = RR_DMA;
        else              win = RR_NONE;
      end
      default: begin
        if (cand[0])      win = RR_CPU;
        else if (cand[1]) win = RR_DMA;
        else if (cand[2]) win = RR_TM;
        else              win = RR_NONE;
      end
    endcase
    return win;
  endfunction

  // Slot decision: everything moves only on a c3 edge, ack echoes the ending slot.
  always_comb begin
    gnt_d        = gnt_q;
    gnt_ref_d    = gnt_ref_q;
    ack_d        = 4'b0000;
    vid_run_d    = vid_run_q;
    ref_cnt_d    = ref_cnt_q;
    ref_pend_d   = ref_pend_q;
    rr_d         = rr_q;
    ref_expire_s = (ref_cnt_q == 8'd0);
    vid_capped_s = (vid_run_q == VID_CAP) && (bus.req[3:1] != 3'b000);
    rr_win_s     = rr_pick(rr_q, bus.req[3:1]);

    if (bus.c3) begin
      ack_d     = gnt_q;
      gnt_d     = 4'b0000;
      gnt_ref_d = 1'b0;
      if (ref_expire_s) begin
        ref_cnt_d = REF_RELOAD;
      end else begin
        ref_cnt_d = ref_cnt_q - 8'd1;
      end

      if (ref_pend_q) begin
        gnt_ref_d = 1'b1;
      end else if (bus.req[0] && !vid_capped_s) begin
        gnt_d = 4'b0001;
        if (vid_run_q >= VID_CAP) begin
          vid_run_d = VID_CAP;
        end else begin
          vid_run_d = vid_run_q + 3'd1;
        end
      end else if (rr_win_s != RR_NONE) begin
        vid_run_d = 3'd0;
        rr_d      = rr_win_s;
        case (rr_win_s)
          RR_CPU:  gnt_d = 4'b0010;
          RR_DMA:  gnt_d = 4'b0100;
          RR_TM:   gnt_d = 4'b1000;
          default: gnt_d = 4'b0000;
        endcase
      end else begin
        vid_run_d = 3'd0;
      end

      // A fresh expiry on the grant edge keeps the request pending.
      if (ref_expire_s) begin
        ref_pend_d = 1'b1;
      end else if (gnt_ref_d) begin
        ref_pend_d = 1'b0;
      end else begin
        ref_pend_d = ref_pend_q;
      end
    end else begin
      ack_d = 4'b0000;
    end

    busy_d = (gnt_d != 4'b0000) || gnt_ref_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= 4'b0000;
      gnt_ref_q  <= 1'b0;
      ack_q      <= 4'b0000;
      busy_q     <= 1'b0;
      vid_run_q  <= 3'd0;
      ref_cnt_q  <= REF_RELOAD;
      ref_pend_q <= 1'b0;
      rr_q       <= RR_TM;
    end else begin
      gnt_q      <= gnt_d;
      gnt_ref_q  <= gnt_ref_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      vid_run_q  <= vid_run_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      rr_q       <= rr_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_ref = gnt_ref_q;
  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mem_slot_arb.sv
// Bench for mem_slot_arb: two instances (default and short-refresh) run in
// lockstep against a slot-level reference model, plus vectors and sequences.
module tb_mem_slot_arb;

  logic clk;
  logic rst;

  mem_slot_arb_if a_if ();
  mem_slot_arb_if r_if ();

  mem_slot_arb #(.VID_MAX(3), .REF_INT(64)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  mem_slot_arb #(.VID_MAX(2), .REF_INT(4))  dut_r (.clk(clk), .rst(rst), .bus(r_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // Reference model state, index 0 = dut_a, 1 = dut_r.
  int         m_vmax [2];
  int         m_rint [2];
  int         m_vid  [2];
  int         m_cnt  [2];
  int         m_last [2];
  bit         m_pend [2];
  logic [3:0] m_gnt  [2];
  logic       m_ref  [2];
  logic [3:0] m_ack  [2];

  typedef struct {
    logic       r;
    logic       c;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gref;
    logic [3:0] ack;
    logic       busy;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int i, input logic r, input logic c, input logic [3:0] q);
    int owner;
    int cand;
    bit expire;
    if (r) begin
      m_gnt[i]  = 4'b0000;
      m_ref[i]  = 1'b0;
      m_ack[i]  = 4'b0000;
      m_vid[i]  = 0;
      m_pend[i] = 1'b0;
      m_cnt[i]  = m_rint[i] - 1;
      m_last[i] = 3;
    end else if (c) begin
      m_ack[i] = m_gnt[i];
      expire   = (m_cnt[i] == 0);
      m_cnt[i] = expire ? m_rint[i] - 1 : m_cnt[i] - 1;
      owner    = -1;
      if (m_pend[i]) begin
        owner = 4;
      end else if (q[0] && !(m_vid[i] == m_vmax[i] && q[3:1] != 3'b000)) begin
        owner = 0;
      end else begin
        for (int k = 1; k <= 3; k++) begin
          cand = (m_last[i] - 1 + k) % 3 + 1;
          if (owner < 0 && q[cand]) owner = cand;
        end
      end
      if (expire) m_pend[i] = 1'b1;
      else if (owner == 4) m_pend[i] = 1'b0;
      if (owner == 0) m_vid[i] = (m_vid[i] < m_vmax[i]) ? m_vid[i] + 1 : m_vmax[i];
      else if (owner != 4) m_vid[i] = 0;
      if (owner >= 1 && owner <= 3) m_last[i] = owner;
      m_gnt[i] = (owner >= 0 && owner <= 3) ? (4'b0001 << owner) : 4'b0000;
      m_ref[i] = (owner == 4);
    end else begin
      m_ack[i] = 4'b0000;
    end
  endtask

  function automatic logic [9:0] mexp(input int i);
    return {m_gnt[i], m_ref[i], m_ack[i], (m_gnt[i] != 4'b0000) || m_ref[i]};
  endfunction

  task automatic tick(input logic r, input logic c, input logic [3:0] q);
    rst      = r;
    a_if.c3  = c;
    a_if.req = q;
    r_if.c3  = c;
    r_if.req = q;
    @(posedge clk);
    model_edge(0, r, c, q);
    model_edge(1, r, c, q);
    #1;
    chk("model_a", {6'd0, a_if.gnt, a_if.gnt_ref, a_if.ack, a_if.busy}, {6'd0, mexp(0)});
    chk("model_r", {6'd0, r_if.gnt, r_if.gnt_ref, r_if.ack, r_if.busy}, {6'd0, mexp(1)});
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 4'b0000);
    tick(1'b1, 1'b0, 4'b0000);
  endtask

  logic [3:0] vcap_exp [12];
  logic [3:0] rq;
  bit         exp_ref;
  bit         prev_ref;

  initial begin
    errors    = 0;
    checks    = 0;
    m_vmax[0] = 3;  m_rint[0] = 64;
    m_vmax[1] = 2;  m_rint[1] = 4;
    for (int i = 0; i < 2; i++) begin
      m_vid[i] = 0; m_cnt[i] = m_rint[i] - 1; m_last[i] = 3; m_pend[i] = 1'b0;
      m_gnt[i] = 4'b0000; m_ref[i] = 1'b0; m_ack[i] = 4'b0000;
    end
    rst = 1'b1; a_if.c3 = 1'b0; a_if.req = 4'b0000; r_if.c3 = 1'b0; r_if.req = 4'b0000;

    // {rst, c3, req} -> {gnt, gnt_ref, ack, busy} after the edge, for dut_a.
    tbl[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0000, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 4'b0100, 4'b0010, 1'b0, 4'b0000, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0000, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 4'b0110, 4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 4'b0110, 4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 4'b0110, 4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 4'b0110, 4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[23] = '{1'b0, 1'b1, 4'b0110, 4'b0010, 1'b0, 4'b0100, 1'b1};
    tbl[24] = '{1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0000, 1'b1};

    for (int v = 0; v < 25; v++) begin
      tick(tbl[v].r, tbl[v].c, tbl[v].req);
      chk($sformatf("vec%0d", v), {6'd0, a_if.gnt, a_if.gnt_ref, a_if.ack, a_if.busy},
          {6'd0, tbl[v].gnt, tbl[v].gref, tbl[v].ack, tbl[v].busy});
    end

    // All four requesting: three video slots, then one round-robin slot.
    vcap_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001,
                 4'b0001, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b1000};
    do_reset();
    for (int s = 0; s < 12; s++) begin
      tick(1'b0, 1'b1, 4'b1111);
      chk($sformatf("vcap_slot%0d", s), {12'd0, a_if.gnt}, {12'd0, vcap_exp[s]});
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 4'b1111);
    end

    // Video alone is never capped.
    do_reset();
    for (int s = 0; s < 10; s++) begin
      tick(1'b0, 1'b1, 4'b0001);
      chk($sformatf("vid_only%0d", s), {12'd0, a_if.gnt}, {12'd0, 4'b0001});
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 4'b0001);
    end

    // Short refresh interval with cpu requesting; a c3 during reset must not count.
    do_reset();
    tick(1'b1, 1'b1, 4'b0010);
    tick(1'b0, 1'b0, 4'b0010);
    prev_ref = 1'b0;
    for (int s = 1; s <= 12; s++) begin
      exp_ref = (s >= 5) && (s % 4 == 1);
      tick(1'b0, 1'b1, 4'b0010);
      chk($sformatf("ref_slot%0d", s), {7'd0, r_if.gnt, r_if.gnt_ref, r_if.ack},
          {7'd0, exp_ref ? 4'b0000 : 4'b0010, exp_ref,
           (s >= 2 && !prev_ref) ? 4'b0010 : 4'b0000});
      prev_ref = exp_ref;
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 4'b0010);
    end

    // Reset in the second cycle of a cpu slot aborts it without an ack.
    do_reset();
    tick(1'b0, 1'b1, 4'b0010);
    chk("abort_grant", {12'd0, a_if.gnt}, {12'd0, 4'b0010});
    tick(1'b0, 1'b0, 4'b0010);
    tick(1'b1, 1'b0, 4'b0010);
    chk("abort_rst", {7'd0, a_if.gnt, a_if.busy, a_if.ack}, 16'd0);
    tick(1'b0, 1'b0, 4'b0010);
    tick(1'b0, 1'b0, 4'b0010);
    tick(1'b0, 1'b1, 4'b0010);
    chk("abort_regrant", {8'd0, a_if.gnt, a_if.ack}, {8'd0, 4'b0010, 4'b0000});
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 4'b0010);
    tick(1'b0, 1'b1, 4'b0010);
    chk("abort_next_ack", {12'd0, a_if.ack}, {12'd0, 4'b0010});

    // Random requests and occasional resets against the model.
    do_reset();
    rq = 4'b0000;
    for (int cyc = 0; cyc < 2400; cyc++) begin
      if (cyc % 4 == 0 || $urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      tick(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0, (cyc % 4 == 0) ? 1'b1 : 1'b0, rq);
      chk("excl_a", {15'd0, $onehot0({a_if.gnt, a_if.gnt_ref})}, 16'd1);
      chk("excl_r", {15'd0, $onehot0({r_if.gnt, r_if.gnt_ref})}, 16'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
